hilo_div: RTL

- Iterative radix-2 restoring divider for DIV/DIVU.
- Sits directly upstream of the HI/LO register pair: it accepts operands from EX and drives the HI/LO write port on completion (HI = remainder, LO = quotient).
- Holds one operation at a time and exposes busy so the pipeline can stall.
- Supports cancel for exception/flush.

---
 rtl/hilo_div.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hilo_div.sv
// Iterative radix-2 restoring divider feeding the HI/LO write port (HI = remainder, LO = quotient).
// Optional HILO_DIV_ZERO_FAST_EN: divide-by-zero bypasses the iteration loop.
module hilo_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [1:0]        hilo_wen,
    output logic [DATA_W-1:0] hi_wdata,
    output logic [DATA_W-1:0] lo_wdata
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
`ifdef HILO_DIV_ZERO_FAST_EN
        S_FIX,
        S_ZERO
`else
        S_FIX
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   rem_ext, trial;

    // The dividend magnitude is parked in quo and shifted into rem one bit per step.
    assign a_mag   = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
    assign b_mag   = (signed_op && divisor[DATA_W-1])  ? -divisor  : divisor;
    assign rem_ext = {rem_q, quo_q[DATA_W-1]};
    assign trial   = rem_ext - {1'b0, dvs_q};

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        qneg_d  = signed_op & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        rneg_d  = signed_op & dividend[DATA_W-1];
                        state_d = S_CALC;
`ifdef HILO_DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            quo_d   = '1;
                            rem_d   = a_mag;
                            state_d = S_ZERO;
                        end
`endif
                    end
                end
                S_CALC: begin
                    // A negative trial (borrow in the extra bit) restores the shifted remainder.
                    quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
                    rem_d = trial[DATA_W] ? rem_ext[DATA_W-1:0] : trial[DATA_W-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    lo_d    = qneg_q ? -quo_q : quo_q;
                    hi_d    = rneg_q ? -rem_q : rem_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef HILO_DIV_ZERO_FAST_EN
                S_ZERO: begin
                    state_d = S_FIX;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign hilo_wen = {done_q, done_q};
    assign hi_wdata = hi_q;
    assign lo_wdata = lo_q;

endmodule
